aes_key_sched_seq: RTL and testbench
====================================

Name: aes_key_sched_seq

Overview:
Iterative, parametrised AES key-schedule engine replacing the combinational 128-bit expander. Supports AES-128/192/256 via parameter NK. Generates one 32-bit schedule word per clock and streams 128-bit round keys 0..NR out over a valid/ready handshake. Sits between the key-load interface and the round datapath or round-key store.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8 only; any other value is an elaboration error.
NR, NK+6, number of rounds; derived, not overridable.
KEY_W, 32*NK, width of key_in; derived.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request to expand key_in.
start_ready  output  1  engine idle; start accepted when start && start_ready.
key_in  input  KEY_W  cipher key, FIPS-197 byte order; word0 = key_in[KEY_W-1 -: 32].
rk_valid  output  1  rk_data/rk_index valid.
rk_ready  input  1  consumer accepts round key when rk_valid && rk_ready.
rk_data  output  128  round key; [127:96] = w[4r], [31:0] = w[4r+3].
rk_index  output  4  round number r, 0..NR.
rk_last  output  1  high with rk_valid when rk_index == NR.
busy  output  1  expansion in progress or round key pending.
done  output  1  one-cycle pulse the cycle after the last round key is accepted.

Behaviour:
- Reset (async, rst_n low): state IDLE; start_ready=1; rk_valid=0; rk_data=0; rk_index=0; rk_last=0; busy=0; done=0; word counter, rcon, window and assembly registers cleared.
- States: IDLE -> GEN (on start handshake) -> DRAIN (after last word w[4*NR+3] is produced) -> IDLE (when the last round key is accepted).
- IDLE: start_ready=1. On start handshake, latch key_in into an NK-word window, word counter i=0, rcon=8'h01, start_ready=0, busy=1.
- GEN: one word per non-stalled cycle into a 4-word assembly buffer.
  - i<NK: word = key word i.
  - i>=NK, i%NK==0: w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; afterwards rcon = xtime(rcon), where 80 -> 1b.
  - NK==8, i%8==4: w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w[i-NK] ^ w[i-1].
  - Window shifts by one word per produced word.
- Assembly transfers to the output register when 4 words are present and the output register is empty or is being accepted this cycle. Generation stalls only when the assembly buffer is full and the output cannot take it.
- No backpressure (rk_ready tied 1): round key r first has rk_valid high 4*(r+1) cycles after the start-handshake edge; keys are spaced exactly 4 cycles apart; total 4*(NR+1) cycles to the last key.
- rk_data, rk_index and rk_last hold stable while rk_valid && !rk_ready; rk_valid never drops without a handshake.
- Total words produced = 4*(NR+1); rk_index wraps to 0 only on a new start.
- start asserted while busy is ignored: no latch, no effect.
- done pulses exactly once per expansion; start_ready returns to 1 in the same cycle as done.
- rst_n asserted mid-expansion aborts immediately and returns to the reset state; no partial key emitted after release.
- SubWord uses an internal 256-entry AES forward S-box function, 4 instances, combinational.

Optional Feature:
KEY_ZEROIZE_EN
- Defined: on the cycle the last round key is accepted, window, assembly buffer and rk_data are cleared to 0.
- Not defined: those registers retain final values (rk_data holds round NR) until the next start or reset.
- Handshake timing is identical either way.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk0 = key at cycle 4; rk1 = a0fafe1788542cb123a339392a6c7605 at cycle 8; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 at cycle 44; done pulses at cycle 45.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 round keys; rk12[31:0] = 01002202; rk_index sequence 0..12.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk14 = fe4890d1e6188d0b046df344706c631e.
- Backpressure: NK=4, rk_ready low for 10 cycles after rk2 is valid -> rk2 held stable; generation stalls; rk3..rk10 values unchanged vs. the no-stall run; no key lost or duplicated.
- start pulsed during busy, and rst_n low mid-GEN at cycle 15 -> start ignored; after reset all outputs 0, start_ready=1; a fresh start reproduces the golden keys.
- KEY_ZEROIZE_EN defined vs. undefined -> rk_data == 0 vs. == rk10 two cycles after the final accept.

Source files
------------

// File: rtl/aes_key_sched_seq_if.sv
// Key-load / round-key streaming bus of the iterative AES key-schedule engine.
// master: key loader and round-key consumer; slave: the engine.
interface aes_key_sched_seq_if #(
  parameter int NK = 4
);
  logic              start;
  logic              start_ready;
  logic [32*NK-1:0]  key_in;
  logic              rk_valid;
  logic              rk_ready;
  logic [127:0]      rk_data;
  logic [3:0]        rk_index;
  logic              rk_last;
  logic              busy;
  logic              done;

  modport master (
    output start, key_in, rk_ready,
    input  start_ready, rk_valid, rk_data, rk_index, rk_last, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output start_ready, rk_valid, rk_data, rk_index, rk_last, busy, done
  );
endinterface

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock, round keys streamed over valid/ready.
// Optional build macro KEY_ZEROIZE_EN clears window, assembly buffer and rk_data after the final key is taken.
//
// state | meaning
// IDLE  | waiting for start; start_ready high
// GEN   | producing schedule words into the assembly buffer
// DRAIN | all words produced; waiting for the last round key to be accepted
module aes_key_sched_seq #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_key_sched_seq_if.slave bus
);

  localparam int NR      = NK + 6;
  localparam int KEY_W   = 32 * NK;
  localparam int N_WORDS = 4 * (NR + 1);

  generate
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_key_sched_seq: NK must be 4, 6 or 8");
    end
  endgenerate

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state;
  logic [31:0]   win [NK];
  logic [31:0]   asm_w [3];
  logic [1:0]    asm_cnt;
  logic [5:0]    wcnt;
  logic [2:0]    pos;
  logic [7:0]    rcon;
  logic [3:0]    key_cnt;

  logic          start_ready_q;
  logic          rk_valid_q;
  logic [127:0]  rk_data_q;
  logic [3:0]    rk_index_q;
  logic          rk_last_q;
  logic          busy_q;
  logic          done_q;

  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   gen_word;
  logic          rk_accept;
  logic          out_free;
  logic          gen_fire;

  assign rk_accept = rk_valid_q && bus.rk_ready;
  assign out_free  = !rk_valid_q || bus.rk_ready;
  // The 4th word goes straight to the output with the three buffered ones,
  // so only that word can stall on a blocked output register.
  assign gen_fire  = (state == GEN) && ((asm_cnt != 2'd3) || out_free);

  // Single shared SubWord: RotWord applies only at the i%NK==0 positions.
  assign sub_in  = (pos == 3'd0) ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
  assign sub_out = sub_word(sub_in);

  always_comb begin
    gen_word = win[0] ^ win[NK-1];
    if (wcnt < 6'(NK)) begin
      gen_word = win[0];
    end else if (pos == 3'd0) begin
      gen_word = win[0] ^ sub_out ^ {rcon, 24'h000000};
    end else if (NK == 8 && pos == 3'd4) begin
      gen_word = win[0] ^ sub_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_ready_q <= 1'b1;
      rk_valid_q    <= 1'b0;
      rk_data_q     <= '0;
      rk_index_q    <= '0;
      rk_last_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wcnt          <= '0;
      pos           <= '0;
      rcon          <= '0;
      key_cnt       <= '0;
      asm_cnt       <= '0;
      for (int j = 0; j < NK; j++) win[j] <= '0;
      for (int j = 0; j < 3; j++) asm_w[j] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && start_ready_q) begin
            for (int j = 0; j < NK; j++) win[j] <= bus.key_in[KEY_W-1-32*j -: 32];
            wcnt          <= '0;
            pos           <= '0;
            rcon          <= 8'h01;
            key_cnt       <= '0;
            asm_cnt       <= '0;
            rk_data_q     <= '0;
            rk_index_q    <= '0;
            rk_last_q     <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= GEN;
          end
        end

        GEN: begin
          if (rk_accept) rk_valid_q <= 1'b0;
          if (gen_fire) begin
            // Window runs oldest-first: win[0] = w[i-NK], win[NK-1] = w[i-1].
            for (int j = 0; j < NK-1; j++) win[j] <= win[j+1];
            win[NK-1] <= gen_word;
            wcnt      <= wcnt + 6'd1;
            pos       <= (pos == 3'(NK-1)) ? 3'd0 : pos + 3'd1;
            if (wcnt >= 6'(NK) && pos == 3'd0) rcon <= xtime(rcon);
            if (asm_cnt == 2'd3) begin
              rk_data_q  <= {asm_w[0], asm_w[1], asm_w[2], gen_word};
              rk_valid_q <= 1'b1;
              rk_index_q <= key_cnt;
              rk_last_q  <= (key_cnt == 4'(NR));
              key_cnt    <= key_cnt + 4'd1;
              asm_cnt    <= '0;
            end else begin
              case (asm_cnt)
                2'd0:    asm_w[0] <= gen_word;
                2'd1:    asm_w[1] <= gen_word;
                default: asm_w[2] <= gen_word;
              endcase
              asm_cnt <= asm_cnt + 2'd1;
            end
            if (wcnt == 6'(N_WORDS-1)) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (rk_accept) begin
            rk_valid_q <= 1'b0;
            if (rk_last_q) begin
              state         <= IDLE;
              done_q        <= 1'b1;
              start_ready_q <= 1'b1;
              busy_q        <= 1'b0;
`ifdef KEY_ZEROIZE_EN
              rk_data_q <= '0;
              for (int j = 0; j < NK; j++) win[j] <= '0;
              for (int j = 0; j < 3; j++) asm_w[j] <= '0;
`endif
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.rk_valid    = rk_valid_q;
  assign bus.rk_data     = rk_data_q;
  assign bus.rk_index    = rk_index_q;
  assign bus.rk_last     = rk_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed bench for aes_key_sched_seq: FIPS-197 vectors for NK=4/6/8, backpressure, busy-start, mid-run reset.
module tb_aes_key_sched_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_sched_seq_if #(.NK(4)) if4 ();
  aes_key_sched_seq_if #(.NK(6)) if6 ();
  aes_key_sched_seq_if #(.NK(8)) if8 ();

  aes_key_sched_seq #(.NK(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  aes_key_sched_seq #(.NK(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));
  aes_key_sched_seq #(.NK(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  localparam logic [127:0] KEY4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int errors = 0;
  int checks = 0;

  logic [127:0] g128 [11];
  logic [127:0] cap4 [16];
  logic [127:0] cap6 [16];
  logic [127:0] cap8 [16];
  int           cyc4 [16];
  int           idx4 [16];
  int           last4 [16];
  int           idx6 [16];
  int           n4, n6, n8;
  int           done4, done6, done8, done4_cnt, sr4, busy_done4;
  int           sr_mid, busy_mid;
  logic [127:0] z4;
  int           hold, bp_started, unstable, drops, prev_v, prev_r;
  logic [127:0] snap;
  int           live;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    for (int k = 0; k < 16; k++) begin
      cap4[k] = '0; cap6[k] = '0; cap8[k] = '0;
      cyc4[k] = -1; idx4[k] = -1; last4[k] = -1; idx6[k] = -1;
    end
    n4 = 0; n6 = 0; n8 = 0;
    done4 = -1; done6 = -1; done8 = -1; done4_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, 128'(if4.start_ready), 128'(1));
    chk({tag, "_rk_valid"},    128'(if4.rk_valid),    128'(0));
    chk({tag, "_rk_data"},     if4.rk_data,           128'h0);
    chk({tag, "_rk_index"},    128'(if4.rk_index),    128'(0));
    chk({tag, "_rk_last"},     128'(if4.rk_last),     128'(0));
    chk({tag, "_busy"},        128'(if4.busy),        128'(0));
    chk({tag, "_done"},        128'(if4.done),        128'(0));
  endtask

  initial begin
    g128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    g128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    g128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    g128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    g128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    g128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    g128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    g128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    g128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    g128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    g128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    if4.start = 1'b0; if6.start = 1'b0; if8.start = 1'b0;
    if4.rk_ready = 1'b1; if6.rk_ready = 1'b1; if8.rk_ready = 1'b1;
    if4.key_in = '0; if6.key_in = '0; if8.key_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");

    // ---- Run A: all three key sizes, no backpressure, stray start while busy
    clear_caps();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if4.key_in = KEY4; if6.key_in = KEY6; if8.key_in = KEY8;
    if4.start = 1'b1; if6.start = 1'b1; if8.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0; if6.start = 1'b0; if8.start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (c == 10) begin
        sr_mid = int'(if4.start_ready); busy_mid = int'(if4.busy);
        if4.key_in = ~KEY4; if6.key_in = ~KEY6; if8.key_in = ~KEY8;
        if4.start = 1'b1; if6.start = 1'b1; if8.start = 1'b1;
      end else begin
        if4.start = 1'b0; if6.start = 1'b0; if8.start = 1'b0;
      end
      if (if4.rk_valid) begin
        if (n4 < 16) begin
          cap4[n4] = if4.rk_data; cyc4[n4] = c;
          idx4[n4] = int'(if4.rk_index); last4[n4] = int'(if4.rk_last);
        end
        n4++;
      end
      if (if6.rk_valid) begin
        if (n6 < 16) begin cap6[n6] = if6.rk_data; idx6[n6] = int'(if6.rk_index); end
        n6++;
      end
      if (if8.rk_valid) begin
        if (n8 < 16) cap8[n8] = if8.rk_data;
        n8++;
      end
      if (if4.done) begin
        done4_cnt++; done4 = c; sr4 = int'(if4.start_ready); busy_done4 = int'(if4.busy);
      end
      if (if6.done) done6 = c;
      if (if8.done) done8 = c;
      if (c == 47) z4 = if4.rk_data;
    end

    chk("busy_start_ready", 128'(sr_mid), 128'(0));
    chk("busy_flag", 128'(busy_mid), 128'(1));
    chk("nk4_key_count", 128'(n4), 128'(11));
    for (int r = 0; r < 11; r++) begin
      chk($sformatf("nk4_rk%0d_data", r), cap4[r], g128[r]);
      chk($sformatf("nk4_rk%0d_cycle", r), 128'(cyc4[r]), 128'(4*(r+1)));
      chk($sformatf("nk4_rk%0d_index", r), 128'(idx4[r]), 128'(r));
      chk($sformatf("nk4_rk%0d_last", r), 128'(last4[r]), 128'(r == 10 ? 1 : 0));
    end
    chk("nk4_done_cycle", 128'(done4), 128'(45));
    chk("nk4_done_pulses", 128'(done4_cnt), 128'(1));
    chk("nk4_start_ready_at_done", 128'(sr4), 128'(1));
    chk("nk4_busy_at_done", 128'(busy_done4), 128'(0));
`ifdef KEY_ZEROIZE_EN
    chk("nk4_zeroized_rk_data", z4, 128'h0);
`else
    chk("nk4_retained_rk_data", z4, g128[10]);
`endif

    chk("nk6_key_count", 128'(n6), 128'(13));
    for (int r = 0; r < 13; r++) chk($sformatf("nk6_rk%0d_index", r), 128'(idx6[r]), 128'(r));
    chk("nk6_rk0", cap6[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    chk("nk6_rk1", cap6[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("nk6_rk12_low", 128'(cap6[12][31:0]), 128'h01002202);
    chk("nk6_done_cycle", 128'(done6), 128'(53));

    chk("nk8_key_count", 128'(n8), 128'(15));
    chk("nk8_rk0", cap8[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("nk8_rk1", cap8[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("nk8_rk14", cap8[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("nk8_done_cycle", 128'(done8), 128'(61));

    // ---- Run B: NK=4 with rk_ready low for 10 cycles once rk2 is valid
    clear_caps();
    hold = 0; bp_started = 0; unstable = 0; drops = 0; prev_v = 0; prev_r = 1;
    if4.key_in = KEY4; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (prev_v == 1 && prev_r == 0 && !if4.rk_valid) drops++;
      if (hold == 0 && bp_started == 0 && if4.rk_valid && if4.rk_index == 4'd2) begin
        hold = 10; bp_started = 1; snap = if4.rk_data;
      end
      if (hold > 0) begin
        if4.rk_ready = 1'b0;
        if (!if4.rk_valid || if4.rk_data !== snap || if4.rk_index !== 4'd2 || if4.rk_last !== 1'b0)
          unstable++;
        hold--;
      end else begin
        if4.rk_ready = 1'b1;
      end
      if (if4.rk_valid && if4.rk_ready) begin
        if (n4 < 16) begin cap4[n4] = if4.rk_data; idx4[n4] = int'(if4.rk_index); end
        n4++;
      end
      if (if4.done) begin done4_cnt++; done4 = c; end
      prev_v = int'(if4.rk_valid); prev_r = int'(if4.rk_ready);
    end
    if4.rk_ready = 1'b1;
    chk("bp_stall_seen", 128'(bp_started), 128'(1));
    chk("bp_hold_unstable", 128'(unstable), 128'(0));
    chk("bp_valid_drops", 128'(drops), 128'(0));
    chk("bp_key_count", 128'(n4), 128'(11));
    for (int r = 0; r < 11; r++) begin
      chk($sformatf("bp_rk%0d_data", r), cap4[r], g128[r]);
      chk($sformatf("bp_rk%0d_index", r), 128'(idx4[r]), 128'(r));
    end
    chk("bp_done_cycle", 128'(done4), 128'(52));
    chk("bp_done_pulses", 128'(done4_cnt), 128'(1));

    // ---- Run C: reset mid-GEN at cycle 15, then a fresh expansion
    if4.key_in = KEY4; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk); rst_n = 1'b1;
    live = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (if4.rk_valid || if4.busy || !if4.start_ready) live++;
    end
    chk("post_reset_quiet", 128'(live), 128'(0));

    clear_caps();
    if4.key_in = KEY4; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (if4.rk_valid) begin
        if (n4 < 16) begin cap4[n4] = if4.rk_data; cyc4[n4] = c; end
        n4++;
      end
      if (if4.done) done4 = c;
    end
    chk("fresh_key_count", 128'(n4), 128'(11));
    for (int r = 0; r < 11; r++) chk($sformatf("fresh_rk%0d_data", r), cap4[r], g128[r]);
    chk("fresh_rk0_cycle", 128'(cyc4[0]), 128'(4));
    chk("fresh_done_cycle", 128'(done4), 128'(45));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
